// File: rtl/reg_file_if.sv
// Operand/write-back bundle between the register file and its neighbours.
// The register file is the slave. Decode and write-back drive it as the master.
interface reg_file_if #(
  parameter int DATA_W = 32,
  parameter int AW     = 5
);
  logic        [AW-1:0]     rs_addr;
  logic        [AW-1:0]     rt_addr;
  logic        [AW-1:0]     rd_addr;
  logic        [DATA_W-1:0] write_data;
  logic                     reg_write;
  logic signed [DATA_W-1:0] rs;
  logic        [DATA_W-1:0] rs_unsigned;
  logic signed [DATA_W-1:0] rt;
  logic        [DATA_W-1:0] rt_unsigned;
  logic        [AW-1:0]     dbg_addr;
  logic        [DATA_W-1:0] dbg_data;

  modport slave (
    input  rs_addr, rt_addr, rd_addr, write_data, reg_write, dbg_addr,
    output rs, rs_unsigned, rt, rt_unsigned, dbg_data
  );

  modport master (
    output rs_addr, rt_addr, rd_addr, write_data, reg_write, dbg_addr,
    input  rs, rs_unsigned, rt, rt_unsigned, dbg_data
  );
endinterface

// File: rtl/reg_file.sv
// MIPS 2R/1W register file. $0 is hardwired to zero. Reads are purely
// combinational, so the ALU can sample on the falling edge. Optional
// same-cycle forwarding lets write_data reach a read port before it commits.

// One read port: array lookup with optional forwarding of the in-flight write.
module reg_file_rd #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int AW       = 5,
  parameter bit BYPASS   = 1'b1
) (
  input  logic [NUM_REGS-1:0][DATA_W-1:0] view,
  input  logic [AW-1:0]                   addr,
  input  logic                            fwd_en,
  input  logic [AW-1:0]                   rd_addr,
  input  logic [DATA_W-1:0]               write_data,
  output logic [DATA_W-1:0]               data
);
  logic hit;

  // fwd_en already excludes $0 and reset, so only the address match is left here.
  always_comb begin
    hit  = BYPASS && fwd_en && (addr == rd_addr);
    data = hit ? write_data : view[addr];
  end
endmodule

module reg_file #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter bit BYPASS   = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  reg_file_if.slave   bus
);
  localparam int AW = $clog2(NUM_REGS);
  localparam int NP = 2;

  // Only entries 1..NUM_REGS-1 are storage. $0 exists solely in the read view.
  logic [DATA_W-1:0]                regs [NUM_REGS-1:1];
  logic [NUM_REGS-1:0][DATA_W-1:0]  view;
  logic                             wr_en;
  logic [NP-1:0][AW-1:0]            rd_addr_p;
  logic [NP-1:0][DATA_W-1:0]        rd_data_p;

  // A write needs reset released, an enable and a non-zero target.
  // The same qualifier gates forwarding, so $0 and in-reset writes never bypass.
  assign wr_en = reset_n && bus.reg_write && (bus.rd_addr != '0);

  // Async clear of all writable registers. Otherwise commit the write-back.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[bus.rd_addr] <= bus.write_data;
    end
  end

  // Flatten storage into a readable view with $0 forced to zero.
  always_comb begin
    view[0] = '0;
    for (int i = 1; i < NUM_REGS; i++) view[i] = regs[i];
  end

  assign rd_addr_p[0] = bus.rs_addr;
  assign rd_addr_p[1] = bus.rt_addr;

  for (genvar p = 0; p < NP; p++) begin : g_rd
    reg_file_rd #(
      .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .AW(AW), .BYPASS(BYPASS)
    ) u_rd (
      .view       (view),
      .addr       (rd_addr_p[p]),
      .fwd_en     (wr_en),
      .rd_addr    (bus.rd_addr),
      .write_data (bus.write_data),
      .data       (rd_data_p[p])
    );
  end

  // Signed and unsigned views carry the same bits. The debug port never forwards.
  assign bus.rs          = rd_data_p[0];
  assign bus.rs_unsigned = rd_data_p[0];
  assign bus.rt          = rd_data_p[1];
  assign bus.rt_unsigned = rd_data_p[1];
  assign bus.dbg_data    = view[bus.dbg_addr];
endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file. A forwarding instance (u1) and a non-forwarding instance
// (u0) share one stimulus stream. Expectations are queued from a reference
// array at drive time, then popped and compared once outputs settle.
module tb_reg_file;
  logic clock = 1'b0;
  logic reset_n;

  reg_file_if #(.DATA_W(32), .AW(5)) b1 ();
  reg_file_if #(.DATA_W(32), .AW(5)) b0 ();

  reg_file #(.DATA_W(32), .NUM_REGS(32), .BYPASS(1'b1)) u1 (
    .clock(clock), .reset_n(reset_n), .bus(b1.slave));
  reg_file #(.DATA_W(32), .NUM_REGS(32), .BYPASS(1'b0)) u0 (
    .clock(clock), .reset_n(reset_n), .bus(b0.slave));

  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [32];
  int          checks = 0;
  int          errors = 0;

  // Current stimulus, mirrored into the reference model at each rising edge.
  logic        c_we;
  logic [4:0]  c_wa, c_ra, c_rb, c_da;
  logic [31:0] c_wd;

  function automatic logic [31:0] observe(int sig);
    case (sig)
      0: return b1.rs;
      1: return b1.rs_unsigned;
      2: return b1.rt;
      3: return b1.rt_unsigned;
      4: return b1.dbg_data;
      5: return b0.rs;
      6: return b0.rt;
      7: return b0.dbg_data;
      8: return {31'b0, (b1.rt < 0)};
      default: return 'x;
    endcase
  endfunction

  task automatic expect_v(input string tag, input int sig, input logic [31:0] val);
    exp_t e;
    e.tag = tag; e.sig = sig; e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sig);
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] da);
    c_we = we; c_wa = wa; c_wd = wd; c_ra = ra; c_rb = rb; c_da = da;
    b1.reg_write = we; b1.rd_addr = wa; b1.write_data = wd;
    b1.rs_addr = ra; b1.rt_addr = rb; b1.dbg_addr = da;
    b0.reg_write = we; b0.rd_addr = wa; b0.write_data = wd;
    b0.rs_addr = ra; b0.rt_addr = rb; b0.dbg_addr = da;
  endtask

  task automatic set_reset(input logic v);
    reset_n = v;
    if (!v) for (int i = 0; i < 32; i++) model[i] = '0;
  endtask

  // Cross a rising edge, update the model with any qualified write, then settle.
  task automatic rise();
    @(posedge clock);
    if (reset_n && c_we && c_wa != 5'd0) model[c_wa] = c_wd;
    #1;
  endtask

  // Expected read-port value before the edge: forwarding applies only to u1.
  function automatic logic [31:0] fwd(input logic [4:0] a);
    if (reset_n && c_we && c_wa != 5'd0 && c_wa == a) return c_wd;
    return model[a];
  endfunction

  task automatic expect_pre(input string tag);
    expect_v({tag, "_rs1"}, 0, fwd(c_ra));
    expect_v({tag, "_rt1"}, 2, fwd(c_rb));
    expect_v({tag, "_dbg1"}, 4, model[c_da]);
    expect_v({tag, "_rs0"}, 5, model[c_ra]);
    expect_v({tag, "_rt0"}, 6, model[c_rb]);
    expect_v({tag, "_dbg0"}, 7, model[c_da]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] ra, rb, wa;
    set_reset(1'b0);
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    repeat (2) @(posedge clock);

    // Reset state, checked mid-cycle.
    @(negedge clock);
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd31, 5'd17);
    #1;
    expect_v("rst_rs", 0, 32'h0);
    expect_v("rst_rt", 2, 32'h0);
    expect_v("rst_dbg", 4, 32'h0);
    drain();
    set_reset(1'b1);

    // Basic write/read, including a negative value.
    @(negedge clock); drive(1'b1, 5'd8, 32'h0000_0007, 5'd0, 5'd0, 5'd8); rise();
    @(negedge clock); drive(1'b1, 5'd9, 32'hFFFF_FFF9, 5'd0, 5'd0, 5'd9); rise();
    @(negedge clock); drive(1'b0, 5'd0, 32'h0, 5'd8, 5'd9, 5'd9);
    #1;
    expect_v("basic_rs", 0, 32'h0000_0007);
    expect_v("basic_rsu", 1, 32'h0000_0007);
    expect_v("basic_rt", 2, 32'hFFFF_FFF9);
    expect_v("basic_rtu", 3, 32'hFFFF_FFF9);
    expect_v("basic_rt_neg", 8, 32'h1);
    expect_v("basic_rs0", 5, 32'h0000_0007);
    expect_v("basic_rt0", 6, 32'hFFFF_FFF9);
    drain();

    // $0 is hardwired: no forwarding before the edge and no commit after it.
    @(negedge clock); drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
    #1;
    expect_v("zero_pre_rs", 0, 32'h0);
    expect_v("zero_pre_rt", 2, 32'h0);
    drain();
    rise();
    expect_v("zero_post_rs", 0, 32'h0);
    expect_v("zero_post_rt", 2, 32'h0);
    expect_v("zero_post_dbg", 4, 32'h0);
    drain();

    // Forwarding versus none for a write to $10.
    @(negedge clock); drive(1'b1, 5'd10, 32'h1111_1111, 5'd0, 5'd0, 5'd0); rise();
    @(negedge clock); drive(1'b1, 5'd10, 32'h2222_2222, 5'd10, 5'd10, 5'd10);
    #1;
    expect_v("byp_rs1", 0, 32'h2222_2222);
    expect_v("byp_rt1", 2, 32'h2222_2222);
    expect_v("byp_dbg1", 4, 32'h1111_1111);
    expect_v("nobyp_rs0", 5, 32'h1111_1111);
    expect_v("nobyp_dbg0", 7, 32'h1111_1111);
    drain();
    rise();
    expect_v("byp_post_dbg1", 4, 32'h2222_2222);
    expect_v("nobyp_post_rs0", 5, 32'h2222_2222);
    expect_v("nobyp_post_rt0", 6, 32'h2222_2222);
    drain();

    // Asynchronous clear mid-cycle. A write presented during reset must neither
    // forward nor commit.
    @(negedge clock); drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5, 5'd5); rise();
    @(negedge clock); drive(1'b1, 5'd5, 32'h0000_0001, 5'd5, 5'd10, 5'd5);
    #2;
    set_reset(1'b0);
    #1;
    expect_v("aclr_rs1", 0, 32'h0);
    expect_v("aclr_rs0", 5, 32'h0);
    expect_v("aclr_rt1", 2, 32'h0);
    expect_v("aclr_dbg1", 4, 32'h0);
    drain();
    rise();
    expect_v("inrst_rs1", 0, 32'h0);
    expect_v("inrst_dbg0", 7, 32'h0);
    drain();

    // Reset race: a pending write to $3 is lost when reset falls before the edge.
    @(negedge clock); set_reset(1'b1); drive(1'b1, 5'd3, 32'h5, 5'd3, 5'd0, 5'd3);
    #2;
    set_reset(1'b0);
    rise();
    @(negedge clock); set_reset(1'b1); drive(1'b0, 5'd3, 32'h5, 5'd3, 5'd0, 5'd3);
    #1;
    expect_v("race_lost_dbg", 4, 32'h0);
    expect_v("race_lost_rs0", 5, 32'h0);
    drain();
    @(negedge clock); drive(1'b1, 5'd3, 32'h5, 5'd3, 5'd0, 5'd3); rise();
    expect_v("race_retry_dbg", 4, 32'h5);
    expect_v("race_retry_rs0", 5, 32'h5);
    drain();

    // Randomised traffic checked against the reference model.
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      wa = 5'($urandom_range(0, 31));
      ra = (k % 3 == 0) ? wa : 5'($urandom_range(0, 31));
      rb = (k % 4 == 0) ? wa : 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), wa, $urandom, ra, rb, 5'($urandom_range(0, 31)));
      #1;
      expect_pre("rnd_pre");
      drain();
      rise();
      expect_v("rnd_post_rs1", 0, model[c_ra]);
      expect_v("rnd_post_rs0", 5, model[c_ra]);
      expect_v("rnd_post_rt0", 6, model[c_rb]);
      expect_v("rnd_post_dbg0", 7, model[c_da]);
      drain();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
